calc_arbiter: RTL and testbench

CALC_ARBITER -- requirements
Module: calc_arbiter

---
 rtl/calc_arbiter.sv | 138 +++++++++++++
 tb/tb_calc_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// Two-requester front end for a shared calculator.
// Round-robin grant, single issue, timeout and init abort.
module calc_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [4:0] a0,
   input  logic [4:0] a1,
   input  logic [4:0] b0,
   input  logic [4:0] b1,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic       err0,
   output logic       err1,
   output logic [4:0] result0,
   output logic [4:0] result1,
   output logic [4:0] calc_a,
   output logic [4:0] calc_b,
   output logic [1:0] calc_op_code,
   output logic       calc_op_code_valid,
   input  logic       calc_data_ready,
   input  logic [4:0] calc_z,
   input  logic       calc_initializing,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       gnt;
   logic       last_gnt;
   logic       error;

   logic       pick;
   logic       abort;
   logic       success;
   logic       tmo;
   logic       to_resp;
   logic       resp_err;

   // Next grant and the three ways out of ISSUE/WAIT
   always_comb begin
      pick     = (req0 && req1) ? ~last_gnt : req1;
      abort    = ((state == ISSUE) || (state == WAIT))
                 && calc_initializing;
      success  = (state == WAIT) && !calc_initializing
                 && calc_data_ready;
      tmo      = (state == WAIT) && !calc_initializing
                 && !calc_data_ready && (cnt == TMO_LAST);
      to_resp  = abort || success || tmo;
      resp_err = abort || tmo;
   end

   // Main FSM; every output is a register written here
   always_ff @(posedge clk) begin
      if (!rst) begin
         state              <= IDLE;
         cnt                <= '0;
         gnt                <= 1'b0;
         last_gnt           <= 1'b1;
         error              <= 1'b0;
         ack0               <= 1'b0;
         ack1               <= 1'b0;
         done0              <= 1'b0;
         done1              <= 1'b0;
         err0               <= 1'b0;
         err1               <= 1'b0;
         result0            <= '0;
         result1            <= '0;
         calc_a             <= '0;
         calc_b             <= '0;
         calc_op_code       <= '0;
         calc_op_code_valid <= 1'b0;
         busy               <= 1'b0;
      end else begin
         ack0               <= 1'b0;
         ack1               <= 1'b0;
         done0              <= 1'b0;
         done1              <= 1'b0;
         err0               <= 1'b0;
         err1               <= 1'b0;
         calc_op_code_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!calc_initializing && (req0 || req1)) begin
                  gnt                <= pick;
                  last_gnt           <= pick;
                  calc_a             <= pick ? a1 : a0;
                  calc_b             <= pick ? b1 : b0;
                  calc_op_code       <= pick ? op1 : op0;
                  ack0               <= ~pick;
                  ack1               <= pick;
                  calc_op_code_valid <= 1'b1;
                  busy               <= 1'b1;
                  state              <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               cnt <= (state == ISSUE) ? 8'd0 : cnt + 8'd1;
               if (to_resp) begin
                  state <= RESP;
                  error <= resp_err;
                  done0 <= ~gnt;
                  done1 <= gnt;
                  err0  <= ~gnt && resp_err;
                  err1  <= gnt && resp_err;
                  if (success && !gnt) result0 <= calc_z;
                  if (success && gnt)  result1 <= calc_z;
               end else begin
                  state <= WAIT;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               error <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter: vector table plus
// hand sequences for init gating and reset mid-wait.
module tb_calc_arbiter;

   localparam int TMO     = 16;
   localparam int NEVER   = 255;
   localparam int TMO_LAT = TMO + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [4:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
   logic [1:0] op0 = '0, op1 = '0;
   logic       ack0, ack1, done0, done1, err0, err1;
   logic [4:0] result0, result1, calc_a, calc_b;
   logic [1:0] calc_op_code;
   logic       calc_op_code_valid, busy;
   logic       calc_data_ready = 1'b0;
   logic [4:0] calc_z = '0;
   logic       calc_initializing = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [4:0] exp_res0 = '0;
   logic [4:0] exp_res1 = '0;

   calc_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .op0(op0), .op1(op1),
      .ack0(ack0), .ack1(ack1),
      .done0(done0), .done1(done1),
      .err0(err0), .err1(err1),
      .result0(result0), .result1(result1),
      .calc_a(calc_a), .calc_b(calc_b),
      .calc_op_code(calc_op_code),
      .calc_op_code_valid(calc_op_code_valid),
      .calc_data_ready(calc_data_ready),
      .calc_z(calc_z),
      .calc_initializing(calc_initializing),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r0;
      logic       r1;
      logic [1:0] op;
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] z;
      int         d;
      logic       init;
      logic       gnt;
      logic       err;
      int         lat;
      logic       hold;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h",
                  name, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int n;
      logic got;
      logic [4:0] ea;
      logic [4:0] eb;
      logic [1:0] eo;
      req0 = v.r0;
      req1 = v.r1;
      a0 = v.a;
      b0 = v.b;
      op0 = v.op;
      a1 = v.a ^ 5'h15;
      b1 = v.b ^ 5'h0a;
      op1 = ~v.op;
      calc_initializing = 1'b0;
      calc_data_ready = 1'b0;
      ea = v.gnt ? a1 : a0;
      eb = v.gnt ? b1 : b0;
      eo = v.gnt ? op1 : op0;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) got = 1'b1;
      end
      chk("ack_latency", n, v.lat);
      chk("ack_mask", {ack1, ack0}, {v.gnt, ~v.gnt});
      chk("issue_valid", calc_op_code_valid, 1'b1);
      chk("issue_operands", {calc_a, calc_b, calc_op_code},
          {ea, eb, eo});
      a0 = 5'($urandom);
      a1 = 5'($urandom);
      b0 = 5'($urandom);
      b1 = 5'($urandom);
      op0 = 2'($urandom);
      op1 = 2'($urandom);
      if (!v.hold) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1)
            chk("pulse_one_cycle",
                {calc_op_code_valid, ack1, ack0}, 3'b000);
         if (done0 || done1) begin
            got = 1'b1;
         end else begin
            calc_data_ready = (n == v.d);
            calc_initializing = v.init && (n == v.d);
            calc_z = v.z;
         end
      end
      calc_data_ready = 1'b0;
      calc_initializing = 1'b0;
      if (!v.err) begin
         if (v.gnt) exp_res1 = v.z;
         else exp_res0 = v.z;
      end
      chk("done_latency", n, (v.d == NEVER) ? TMO_LAT : v.d + 1);
      chk("done_mask", {done1, done0}, {v.gnt, ~v.gnt});
      chk("err_flags", {err1, err0},
          {v.gnt & v.err, ~v.gnt & v.err});
      chk("held_operands", {calc_a, calc_b, calc_op_code},
          {ea, eb, eo});
      chk("result0", result0, exp_res0);
      chk("result1", result1, exp_res1);
      chk("busy_in_resp", busy, 1'b1);
   endtask

   initial begin
      int n;
      logic seen;
      //           r0  r1  op     a      b      z      d   in  g   e   lat h
      vecs[0] = '{1'b1,1'b0,2'b01,5'd4, 5'd3, 5'd7, 3,    1'b0,1'b0,1'b0,1,1'b0};
      vecs[1] = '{1'b1,1'b1,2'b10,5'd9, 5'd2, 5'd9, 2,    1'b0,1'b1,1'b0,2,1'b1};
      vecs[2] = '{1'b1,1'b1,2'b11,5'd3, 5'd5, 5'd15,4,    1'b0,1'b0,1'b0,2,1'b1};
      vecs[3] = '{1'b1,1'b1,2'b00,5'd6, 5'd1, 5'd12,1,    1'b0,1'b1,1'b0,2,1'b0};
      vecs[4] = '{1'b0,1'b1,2'b01,5'd1, 5'd1, 5'd2, NEVER,1'b0,1'b1,1'b1,2,1'b0};
      vecs[5] = '{1'b0,1'b1,2'b11,5'd5, 5'd6, 5'h1e,1,    1'b0,1'b1,1'b0,2,1'b0};
      vecs[6] = '{1'b1,1'b0,2'b01,5'd2, 5'd8, 5'd10,2,    1'b1,1'b0,1'b1,2,1'b0};
      vecs[7] = '{1'b1,1'b0,2'b00,5'd17,5'd2, 5'd3, 5,    1'b0,1'b0,1'b0,1,1'b0};
      vecs[8] = '{1'b1,1'b1,2'b01,5'd8, 5'd8, 5'h11,1,    1'b0,1'b0,1'b0,1,1'b0};

      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      chk("reset_outputs",
          {ack0, ack1, done0, done1, err0, err1,
           calc_op_code_valid, busy}, 8'h00);
      chk("reset_regs",
          {result0, result1, calc_a, calc_b, calc_op_code}, 22'h0);

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      calc_initializing = 1'b1;
      req0 = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ack0 || ack1 || busy) seen = 1'b1;
      end
      chk("init_gating", seen, 1'b0);
      run_txn(vecs[7]);

      req0 = 1'b1;
      a0 = 5'd5;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk);
         n++;
         if (ack0) seen = 1'b1;
      end
      chk("rst_pre_ack", seen, 1'b1);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_res0 = '0;
      exp_res1 = '0;
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_outputs",
          {ack0, ack1, done0, done1, err0, err1,
           calc_op_code_valid}, 7'h00);
      chk("rst_mid_regs",
          {result0, result1, calc_a, calc_b, calc_op_code}, 22'h0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done0 || done1 || err0 || err1 || busy) seen = 1'b1;
      end
      chk("rst_no_done", seen, 1'b0);
      run_txn(vecs[8]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
